// File: rtl/text_plane_scheduler.sv
// text_plane_scheduler: owns the 160x120 plot port. A free-running sweep
// presents every pixel once per frame; three 16-cell text rows are rendered
// from an internal cell buffer through an external combinational glyph ROM.
// Cells are written one at a time or bulk-cleared by a small two-state FSM.
//
// Pipeline: stage 0 = sweep counters plus cell lookup, stage 1 = glyph
// address register (drives glyph_*), stage 2 = plot register (drives vga_*).
//
// Handshake: there is no ready/valid flow control. wr_en is a one-cycle
// strobe, accepted only while clr_busy is low, clr_req is low and the
// row/column address is in range; otherwise it is dropped. clr_req is
// accepted only while clr_busy is low, and it beats a coincident wr_en.
module text_plane_scheduler #(
  parameter int COLS   = 16,
  parameter int ROW0_Y = 0,
  parameter int ROW1_Y = 20,
  parameter int ROW2_Y = 80,
  parameter int H_RES  = 160,
  parameter int V_RES  = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [3:0] wr_code,
  input  logic       wr_enable,
  input  logic       clr_req,
  output logic       clr_busy,
  input  logic [2:0] fg_colour,
  output logic [3:0] glyph_code,
  output logic [2:0] glyph_x,
  output logic [3:0] glyph_y,
  input  logic       glyph_pixel,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       frame_done
);

  localparam int         NCELLS   = 3 * COLS;
  localparam logic [5:0] LAST_IDX = 6'(NCELLS - 1);
  localparam logic [7:0] X_LAST   = 8'(H_RES - 1);
  localparam logic [6:0] Y_LAST   = 7'(V_RES - 1);
  localparam logic [6:0] R0_LO    = 7'(ROW0_Y);
  localparam logic [6:0] R1_LO    = 7'(ROW1_Y);
  localparam logic [6:0] R2_LO    = 7'(ROW2_Y);
  localparam logic [4:0] COLS_N   = 5'(COLS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Cell word: {enable, code}
  logic [4:0] cell_q [NCELLS];

  logic [0:0] state_q, state_d;
  logic [5:0] clr_idx_q, clr_idx_d;

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;

  logic       s1_valid_q, s1_show_q;
  logic [7:0] s1_x_q;
  logic [6:0] s1_y_q;
  logic [3:0] glyph_code_q;
  logic [2:0] glyph_x_q;
  logic [3:0] glyph_y_q;

  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;
  logic       vga_plot_q, frame_done_q;

  // Stage-0 lookup signals
  logic [6:0] dy0, dy1, dy2;
  logic       row_hit, hit_d;
  logic [1:0] row_sel;
  logic [3:0] gy_d;
  logic [4:0] col;
  logic [5:0] rd_idx;
  logic [4:0] rd_cell;

  // Write decode signals
  logic       wr_ok;
  logic [5:0] wr_idx;

  // Next-state of the sweep: x every cycle, y on x wrap, both wrap at the frame end
  always_comb begin
    x_d = x_q + 8'd1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = 8'd0;
      y_d = (y_q == Y_LAST) ? 7'd0 : y_q + 7'd1;
    end
  end

  // Hit test: row by band offset (wraps large when above the band), column by x/8
  always_comb begin
    dy0     = y_q - R0_LO;
    dy1     = y_q - R1_LO;
    dy2     = y_q - R2_LO;
    row_hit = 1'b0;
    row_sel = 2'd0;
    gy_d    = 4'd0;
    if (dy0[6:4] == 3'd0) begin
      row_hit = 1'b1;
      row_sel = 2'd0;
      gy_d    = dy0[3:0];
    end else if (dy1[6:4] == 3'd0) begin
      row_hit = 1'b1;
      row_sel = 2'd1;
      gy_d    = dy1[3:0];
    end else if (dy2[6:4] == 3'd0) begin
      row_hit = 1'b1;
      row_sel = 2'd2;
      gy_d    = dy2[3:0];
    end
    col     = x_q[7:3];
    hit_d   = row_hit && (col < COLS_N);
    rd_idx  = 6'(int'(row_sel) * COLS + int'(col));
    rd_cell = hit_d ? cell_q[rd_idx] : 5'd0;
  end

  // Write acceptance: idle, no competing clear, address inside the buffer
  always_comb begin
    wr_ok  = (state_q == ST_IDLE) && !clr_req && wr_en &&
             (wr_row != 2'd3) && ({1'b0, wr_col} < COLS_N);
    wr_idx = 6'(int'(wr_row) * COLS + int'(wr_col));
  end

  // Clear FSM: walk every cell index once, then fall back to idle
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = 6'd0;
        end
      end
      ST_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = 6'd0;
        end else begin
          clr_idx_d = clr_idx_q + 6'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = 6'd0;
      end
    endcase
  end

  // Clear FSM and sweep registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= 6'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Cell buffer: clear has priority; a same-cycle sweep read sees the old word
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCELLS; i++) cell_q[i] <= 5'd0;
    end else if (state_q == ST_CLEAR) begin
      cell_q[clr_idx_q] <= 5'd0;
    end else if (wr_ok) begin
      cell_q[wr_idx] <= {wr_enable, wr_code};
    end
  end

  // Stage 1: glyph address and carried coordinates
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_show_q    <= 1'b0;
      s1_x_q       <= 8'd0;
      s1_y_q       <= 7'd0;
      glyph_code_q <= 4'd0;
      glyph_x_q    <= 3'd0;
      glyph_y_q    <= 4'd0;
    end else begin
      s1_valid_q   <= 1'b1;
      s1_show_q    <= hit_d && rd_cell[4];
      s1_x_q       <= x_q;
      s1_y_q       <= y_q;
      glyph_code_q <= hit_d ? rd_cell[3:0] : 4'd0;
      glyph_x_q    <= hit_d ? x_q[2:0] : 3'd0;
      glyph_y_q    <= hit_d ? gy_d : 4'd0;
    end
  end

  // Stage 2: plot every pixel, lit glyph pixels in fg_colour, others black
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      vga_x_q      <= s1_x_q;
      vga_y_q      <= s1_y_q;
      vga_colour_q <= (s1_show_q && glyph_pixel) ? fg_colour : 3'd0;
      vga_plot_q   <= s1_valid_q;
      frame_done_q <= s1_valid_q && (s1_x_q == X_LAST) && (s1_y_q == Y_LAST);
    end
  end

  assign clr_busy   = (state_q == ST_CLEAR);
  assign glyph_code = glyph_code_q;
  assign glyph_x    = glyph_x_q;
  assign glyph_y    = glyph_y_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_text_plane_scheduler.sv
// Bench for text_plane_scheduler: frame-level reference model (pixel index
// arithmetic over a cell array), a small glyph ROM model, table-driven write
// vectors, hand sequences for clear/reset corners and a randomized phase.
module tb_text_plane_scheduler;

  localparam int COLS   = 16;
  localparam int H      = 160;
  localparam int V      = 120;
  localparam int FRAME  = H * V;
  localparam int NCELLS = 3 * COLS;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_row = '0;
  logic [3:0] wr_col = '0;
  logic [3:0] wr_code = '0;
  logic       wr_enable = 1'b0;
  logic       clr_req = 1'b0;
  logic [2:0] fg_colour = 3'b010;
  logic       clr_busy;
  logic [3:0] glyph_code;
  logic [2:0] glyph_x;
  logic [3:0] glyph_y;
  logic       glyph_pixel;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       frame_done;

  always #5 clk = ~clk;

  text_plane_scheduler dut (
    .CLOCK_50(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_code(wr_code),
    .wr_enable(wr_enable), .clr_req(clr_req), .clr_busy(clr_busy),
    .fg_colour(fg_colour),
    .glyph_code(glyph_code), .glyph_x(glyph_x), .glyph_y(glyph_y),
    .glyph_pixel(glyph_pixel),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .frame_done(frame_done)
  );

  // Model glyph ROM: arbitrary but fixed pattern per (code, x, y)
  function automatic logic rom_bit(logic [3:0] c, logic [2:0] x, logic [3:0] y);
    int v;
    v = int'(c) * 5 + int'(x) * 3 + int'(y) * 7 + int'(x) * int'(y);
    return (v % 3) == 0;
  endfunction

  assign glyph_pixel = rom_bit(glyph_code, glyph_x, glyph_y);

  // ---------------- reference model ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_edges;          // rising edges since reset release
  bit         m_en [NCELLS];
  logic [3:0] m_code [NCELLS];
  int         clr_left;         // cells still to be cleared
  // per swept pixel: {glyph_code, glyph_x, glyph_y, lit}
  logic [11:0] exp_q[$];

  function automatic int row_y(int r);
    return (r == 0) ? 0 : (r == 1) ? 20 : 80;
  endfunction

  function automatic logic [11:0] model_pixel(int x, int y);
    logic [11:0] res;
    logic [3:0]  gc;
    logic [2:0]  gx;
    logic [3:0]  gy;
    int          idx;
    res = '0;
    for (int r = 0; r < 3; r++) begin
      if (y >= row_y(r) && y < row_y(r) + 16 && x < 8 * COLS) begin
        idx = r * COLS + x / 8;
        gc  = m_code[idx];
        gx  = 3'(x % 8);
        gy  = 4'(y - row_y(r));
        res = {gc, gx, gy, m_en[idx] && rom_bit(gc, gx, gy)};
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    n_edges  = 0;
    clr_left = 0;
    exp_q.delete();
    for (int i = 0; i < NCELLS; i++) begin
      m_en[i]   = 1'b0;
      m_code[i] = 4'd0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n_edges, $time);
    end
  endtask

  // One clock: record what the sweep reads now, apply the cell/clear rules,
  // advance, then check glyph (1 cycle later) and plot (2 cycles later).
  task automatic step();
    int          p;
    logic [11:0] g;
    logic [11:0] e;
    p = n_edges % FRAME;
    exp_q.push_back(model_pixel(p % H, p / H));
    if (clr_left > 0) begin
      m_en[NCELLS - clr_left]   = 1'b0;
      m_code[NCELLS - clr_left] = 4'd0;
      clr_left--;
    end else if (clr_req) begin
      clr_left = NCELLS;
    end else if (wr_en && wr_row <= 2 && int'(wr_col) < COLS) begin
      m_en[int'(wr_row) * COLS + int'(wr_col)]   = wr_enable;
      m_code[int'(wr_row) * COLS + int'(wr_col)] = wr_code;
    end
    @(posedge clk);
    #1;
    n_edges++;
    g = exp_q[exp_q.size() - 1];
    chk("glyph_code", 32'(glyph_code), 32'(g[11:8]));
    chk("glyph_x", 32'(glyph_x), 32'(g[7:5]));
    chk("glyph_y", 32'(glyph_y), 32'(g[4:1]));
    chk("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
    if (n_edges >= 2) begin
      e = exp_q[0];
      p = (n_edges - 2) % FRAME;
      chk("vga_plot", 32'(vga_plot), 32'd1);
      chk("vga_x", 32'(vga_x), 32'(p % H));
      chk("vga_y", 32'(vga_y), 32'(p / H));
      chk("vga_colour", 32'(vga_colour), e[0] ? 32'(fg_colour) : 32'd0);
      chk("frame_done", 32'(frame_done), 32'(p == FRAME - 1));
    end else begin
      chk("startup_plot", 32'(vga_plot), 32'd0);
      chk("startup_x", 32'(vga_x), 32'd0);
      chk("startup_y", 32'(vga_y), 32'd0);
      chk("startup_done", 32'(frame_done), 32'd0);
    end
    if (exp_q.size() == 2) void'(exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vga_x"}, 32'(vga_x), 32'd0);
    chk({tag, "_vga_y"}, 32'(vga_y), 32'd0);
    chk({tag, "_vga_colour"}, 32'(vga_colour), 32'd0);
    chk({tag, "_vga_plot"}, 32'(vga_plot), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_clr_busy"}, 32'(clr_busy), 32'd0);
    chk({tag, "_glyph_code"}, 32'(glyph_code), 32'd0);
    chk({tag, "_glyph_x"}, 32'(glyph_x), 32'd0);
    chk({tag, "_glyph_y"}, 32'(glyph_y), 32'd0);
  endtask

  // Assert reset between edges, check the asynchronous effect, release on a negedge
  task automatic apply_reset(input string tag);
    resetn = 1'b0;
    wr_en  = 1'b0;
    clr_req = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic write_cell(input int r, input int c, input int code, input bit en);
    wr_en     = 1'b1;
    wr_row    = 2'(r);
    wr_col    = 4'(c);
    wr_code   = 4'(code);
    wr_enable = en;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_pixel(input int x, input int y);
    while ((n_edges % FRAME) != y * H + x) step();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] code;
    logic       en;
    logic       wen;
    logic       exp_busy;
  } vec_t;

  vec_t vt[6];
  int   busy_cnt;

  initial begin
    vt[0] = '{row: 2'd3, col: 4'd2,  code: 4'd5,  en: 1'b1, wen: 1'b1, exp_busy: 1'b0};
    vt[1] = '{row: 2'd0, col: 4'd15, code: 4'd7,  en: 1'b1, wen: 1'b1, exp_busy: 1'b0};
    vt[2] = '{row: 2'd1, col: 4'd0,  code: 4'd3,  en: 1'b1, wen: 1'b1, exp_busy: 1'b0};
    vt[3] = '{row: 2'd2, col: 4'd15, code: 4'd15, en: 1'b1, wen: 1'b1, exp_busy: 1'b0};
    vt[4] = '{row: 2'd1, col: 4'd8,  code: 4'd9,  en: 1'b1, wen: 1'b0, exp_busy: 1'b0};
    vt[5] = '{row: 2'd3, col: 4'd15, code: 4'd1,  en: 1'b1, wen: 1'b1, exp_busy: 1'b0};

    // Test 1: reset, blank frame, frame_done period
    #2;
    apply_reset("rst0");
    run(FRAME + 2);

    // Test 2/3/5: single glyph, hidden cell, illegal addresses, mid-frame enable
    fg_colour = 3'b010;
    write_cell(0, 4, 12, 1'b1);
    write_cell(2, 10, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wr_en     = vt[i].wen;
      wr_row    = vt[i].row;
      wr_col    = vt[i].col;
      wr_code   = vt[i].code;
      wr_enable = vt[i].en;
      step();
      chk("vec_busy", 32'(clr_busy), 32'(vt[i].exp_busy));
    end
    wr_en = 1'b0;
    run_to_pixel(84, 88);
    write_cell(2, 10, 0, 1'b1);
    run_to_pixel(5, 0);

    // Test 4: fill everything, clear with a coincident write, writes while busy
    fg_colour = 3'b101;
    for (int i = 0; i < NCELLS; i++) write_cell(i / COLS, i % COLS, $urandom_range(0, 15), 1'b1);
    run(200);
    clr_req   = 1'b1;
    wr_en     = 1'b1;
    wr_row    = 2'd0;
    wr_col    = 4'd1;
    wr_code   = 4'd6;
    wr_enable = 1'b1;
    step();
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 60 && clr_busy; k++) begin
      busy_cnt++;
      wr_en   = 1'b1;
      wr_row  = 2'($urandom_range(0, 2));
      wr_col  = 4'($urandom_range(0, 15));
      wr_code = 4'($urandom_range(0, 15));
      step();
    end
    wr_en = 1'b0;
    chk("busy_len", 32'(busy_cnt), 32'd48);
    run(FRAME);

    // Randomized phase
    for (int k = 0; k < 6000; k++) begin
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_row    = 2'($urandom_range(0, 3));
      wr_col    = 4'($urandom_range(0, 15));
      wr_code   = 4'($urandom_range(0, 15));
      wr_enable = 1'($urandom_range(0, 3) != 0);
      clr_req   = ($urandom_range(0, 399) == 0);
      fg_colour = 3'($urandom_range(0, 7));
      step();
    end
    wr_en   = 1'b0;
    clr_req = 1'b0;
    fg_colour = 3'b111;

    // Test 6a: reset in the middle of a clear
    for (int i = 0; i < NCELLS; i++) write_cell(i / COLS, i % COLS, $urandom_range(0, 15), 1'b1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    run(20);
    apply_reset("rst_clr");
    run(6000);

    // Test 6b: reset while pixel (100,50) is on the plot port
    while (n_edges < 50 * H + 100 + 2) step();
    chk("pre_rst_x", 32'(vga_x), 32'd100);
    chk("pre_rst_y", 32'(vga_y), 32'd50);
    apply_reset("rst_mid");
    run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
